r4_sdf_ctrl: RTL and testbench

- Sequencer for a pipelined radix-4 single-path delay-feedback (SDF) FFT built from cascaded r4_unit stages carrying 16-bit signed complex data.
- Accepts a valid/ready sample stream and drives the datapath clock-enable and zero-fill.
- Generates per-stage butterfly phase and twiddle ROM addresses.
- Tags datapath outputs with valid/first/last and flushes the pipe at end of stream.

---
 rtl/fft_r4_pkg.sv | 44 ++++
 rtl/r4_tag_delay.sv | 32 +++
 rtl/r4_sdf_ctrl.sv | 146 ++++++++++++++
 tb/tb_r4_sdf_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_r4_pkg.sv
// Shared types and size helpers for the radix-4 SDF FFT controller.
// All sizes derive from the radix-4 stage count and the per-stage register latency.
package fft_r4_pkg;

  localparam int LOG4N_DEF  = 2;
  localparam int BF_LAT_DEF = 1;

  function automatic int n_of(input int log4n);
    return 1 << (2 * log4n);
  endfunction

  // Cycles from an input sample to its output bin, counted in advances.
  function automatic int lat_of(input int log4n, input int bf_lat);
    return n_of(log4n) - 1 + log4n * bf_lat;
  endfunction

  // Delay-feedback length of stage s.
  function automatic int d_of(input int log4n, input int s);
    return 1 << (2 * (log4n - 1 - s));
  endfunction

  // Counter offset at which stage s sees the start of a frame.
  function automatic int off_of(input int log4n, input int bf_lat, input int s);
    int o;
    o = 0;
    for (int i = 0; i < s; i++) begin
      o = o + 3 * d_of(log4n, i) + bf_lat;
    end
    return o;
  endfunction

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } r4_tag_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } ctrl_state_t;

endpackage

// File: rtl/r4_tag_delay.sv
// Enable-gated delay line for output tags; moves in lockstep with the datapath.
// Synchronous clear drops every in-flight tag.
module r4_tag_delay
  import fft_r4_pkg::*;
#(
  parameter int DEPTH = 17
) (
  input  logic    clk,
  input  logic    i_clr,
  input  logic    i_en,
  input  r4_tag_t i_tag,
  output r4_tag_t o_tag
);

  r4_tag_t r_line [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_line[i] <= '0;
      end
    end else if (i_en) begin
      r_line[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_line[i] <= r_line[i-1];
      end
    end
  end

  assign o_tag = r_line[DEPTH-1];

endmodule

// File: rtl/r4_sdf_ctrl.sv
// Sequencer for a cascaded radix-4 SDF FFT: stream handshake, clock-enable,
// zero-fill flush, per-stage butterfly phase / twiddle addresses and output tagging.
module r4_sdf_ctrl
  import fft_r4_pkg::*;
#(
  parameter int LOG4N  = LOG4N_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  output logic                     o_dp_en,
  output logic                     o_dp_zero,
  output logic [2*LOG4N-1:0]       o_st_phase,
  output logic [2*LOG4N*LOG4N-1:0] o_st_tw,
  output logic                     o_out_valid,
  output logic                     o_out_first,
  output logic                     o_out_last
);

  localparam int W   = 2 * LOG4N;
  localparam int N   = n_of(LOG4N);
  localparam int LAT = lat_of(LOG4N, BF_LAT);
  localparam int FCW = $clog2(LAT + 1);

  localparam logic [W-1:0]   G_LAST = W'(N - 1);
  localparam logic [FCW-1:0] FC_END = FCW'(LAT - 1);

  ctrl_state_t    r_state;
  logic [W-1:0]   r_g;
  logic [FCW-1:0] r_flush_cnt;
  logic           r_in_ready;

  logic         w_ready;
  logic         w_fire;
  logic         w_dp_en;
  logic         w_dp_zero;
  logic [W-1:0] w_g_inc;
  r4_tag_t      w_tag_in;
  r4_tag_t      w_tag_out;

  always_comb begin
    w_ready   = r_in_ready & rst_n;
    w_fire    = i_in_valid & w_ready;
    w_dp_en   = rst_n & ((r_state == FLUSH) | w_fire);
    w_dp_zero = rst_n & (r_state == FLUSH) & ~w_fire;
    w_g_inc   = r_g + 1'b1;
  end

  // The cycle after the last sample of a frame is already the first flush cycle;
  // a sample offered there (g wrapped to 0) starts the next frame with no gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_g         <= '0;
      r_flush_cnt <= '0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_state <= RUN;
            r_g     <= w_g_inc;
          end
        end
        RUN: begin
          if (w_fire) begin
            r_g <= w_g_inc;
            if (r_g == G_LAST) begin
              r_state     <= FLUSH;
              r_flush_cnt <= '0;
            end
          end
        end
        FLUSH: begin
          if (w_fire) begin
            r_state    <= RUN;
            r_g        <= w_g_inc;
            r_in_ready <= 1'b1;
          end else if (r_flush_cnt == FC_END) begin
            r_state    <= IDLE;
            r_g        <= '0;
            r_in_ready <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
            r_g         <= w_g_inc;
            r_in_ready  <= (w_g_inc == '0);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_g        <= '0;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_fire;
    w_tag_in.first = w_fire & (r_g == '0);
    w_tag_in.last  = w_fire & (r_g == G_LAST);
  end

  r4_tag_delay #(
    .DEPTH(LAT)
  ) u_tag_delay (
    .clk  (clk),
    .i_clr(~rst_n),
    .i_en (w_dp_en),
    .i_tag(w_tag_in),
    .o_tag(w_tag_out)
  );

  assign o_in_ready  = w_ready;
  assign o_dp_en     = w_dp_en;
  assign o_dp_zero   = w_dp_zero;
  assign o_out_valid = w_tag_out.valid & w_dp_en;
  assign o_out_first = w_tag_out.first & w_dp_en;
  assign o_out_last  = w_tag_out.last & w_dp_en;

  // D and 4*D are powers of two, so the modulo/divide reduce to mask and shift.
  for (genvar s = 0; s < LOG4N; s++) begin : g_stage
    localparam int           D     = d_of(LOG4N, s);
    localparam int           DSH   = 2 * (LOG4N - 1 - s);
    localparam logic [W-1:0] OFF   = W'(off_of(LOG4N, BF_LAT, s));
    localparam logic [W-1:0] LMASK = W'(4 * D - 1);
    localparam logic [W-1:0] DMASK = W'(D - 1);

    logic [W-1:0] w_l;
    logic [W-1:0] w_idx;
    logic [W-1:0] w_tw;
    logic [1:0]   w_ph;

    assign w_l   = (r_g - OFF) & LMASK;
    assign w_ph  = 2'(w_l >> DSH);
    assign w_idx = w_l & DMASK;
    assign w_tw  = (w_idx * W'(w_ph)) << (2 * s);

    assign o_st_phase[2*s +: 2] = rst_n ? w_ph : 2'b00;
    assign o_st_tw[W*s +: W]    = rst_n ? w_tw : '0;
  end

endmodule

// File: tb/tb_r4_sdf_ctrl.sv
// Bench for r4_sdf_ctrl: directed scenarios plus random valid patterns,
// compared each cycle against a frame/flush/latency reference model.
module tb_r4_sdf_ctrl;

  localparam int LOG4N  = 2;
  localparam int BF_LAT = 1;
  localparam int W      = 2 * LOG4N;
  localparam int N      = 4 ** LOG4N;
  localparam int LAT    = N - 1 + LOG4N * BF_LAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_in_valid = 1'b0;
  logic o_in_ready, o_dp_en, o_dp_zero, o_out_valid, o_out_first, o_out_last;
  logic [W-1:0]       o_st_phase;
  logic [W*LOG4N-1:0] o_st_tw;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: position within frame, remaining zero-fill advances,
  // and the tags of the last LAT advances.
  int m_g = 0;
  int m_flush_left = 0;
  logic [2:0] m_q [$];

  int n_adv = 0, n_cyc = 0, n_outv = 0, n_en = 0, n_zero = 0;
  int ff_adv = 0, of_adv = 0, ff_cyc = 0, of_cyc = 0;
  int n0, e0, z0;

  always #5 clk = ~clk;

  r4_sdf_ctrl #(.LOG4N(LOG4N), .BF_LAT(BF_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .o_dp_en    (o_dp_en),
    .o_dp_zero  (o_dp_zero),
    .o_st_phase (o_st_phase),
    .o_st_tw    (o_st_tw),
    .o_out_valid(o_out_valid),
    .o_out_first(o_out_first),
    .o_out_last (o_out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_off(input int s);
    int o;
    o = 0;
    for (int i = 0; i < s; i++) o = o + 3 * (N / (4 ** (i + 1))) + BF_LAT;
    return o;
  endfunction

  task automatic rst_cycle();
    @(negedge clk);
    rst_n = 1'b0;
    i_in_valid = 1'($urandom_range(0, 1));
    #1;
    chk("rst_in_ready", 32'(o_in_ready), 0);
    chk("rst_dp_en", 32'(o_dp_en), 0);
    chk("rst_dp_zero", 32'(o_dp_zero), 0);
    chk("rst_out", {29'd0, o_out_valid, o_out_first, o_out_last}, 0);
    chk("rst_phase_tw", {24'd0, o_st_phase, o_st_tw}, 0);
    m_q.delete();
    m_g = 0;
    m_flush_left = 0;
    n_cyc++;
  endtask

  task automatic cycle(input bit v);
    int g;
    bit e_ready, e_en, e_zero, fire;
    logic [2:0] tag_new, e_out;
    logic [W-1:0] e_ph;
    logic [W*LOG4N-1:0] e_tw;
    @(negedge clk);
    rst_n = 1'b1;
    i_in_valid = v;
    #1;
    g = m_g;
    if (m_flush_left > 0) begin
      e_ready = (g == 0);
      e_en    = 1'b1;
    end else begin
      e_ready = 1'b1;
      e_en    = v;
    end
    fire    = v & e_ready;
    e_zero  = (m_flush_left > 0) && !fire;
    tag_new = {fire, fire && (g == 0), fire && (g == N - 1)};
    e_out   = 3'b000;
    if (e_en) begin
      if (m_q.size() == LAT) e_out = m_q.pop_front();
      m_q.push_back(tag_new);
    end
    for (int s = 0; s < LOG4N; s++) begin
      int d, l, ph;
      d  = N / (4 ** (s + 1));
      l  = (((g - ref_off(s)) % (4 * d)) + 4 * d) % (4 * d);
      ph = l / d;
      e_ph[2*s +: 2] = 2'(ph);
      e_tw[W*s +: W] = W'(((l % d) * ph * (4 ** s)) % N);
    end
    chk("in_ready", 32'(o_in_ready), 32'(e_ready));
    chk("dp_en", 32'(o_dp_en), 32'(e_en));
    chk("dp_zero", 32'(o_dp_zero), 32'(e_zero));
    chk("out_valid", 32'(o_out_valid), 32'(e_out[2]));
    chk("out_first", 32'(o_out_first), 32'(e_out[1]));
    chk("out_last", 32'(o_out_last), 32'(e_out[0]));
    chk("st_phase", 32'(o_st_phase), 32'(e_ph));
    chk("st_tw", 32'(o_st_tw), 32'(e_tw));
    if (fire && g == 0) begin
      ff_adv = n_adv;
      ff_cyc = n_cyc;
    end
    if (o_out_first) begin
      of_adv = n_adv;
      of_cyc = n_cyc;
    end
    n_outv += 32'(o_out_valid);
    n_en   += 32'(o_dp_en);
    n_zero += 32'(o_dp_zero);
    if (e_en) n_adv++;
    n_cyc++;
    if (fire) begin
      m_flush_left = 0;
      m_g = (g + 1) % N;
      if (g == N - 1) m_flush_left = LAT;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
      m_g = (m_flush_left == 0) ? 0 : (g + 1) % N;
    end
  endtask

  initial begin
    repeat (3) rst_cycle();
    repeat (4) cycle(1'b0);

    // single frame
    n0 = n_outv; e0 = n_en; z0 = n_zero;
    repeat (16) cycle(1'b1);
    repeat (LAT + 4) cycle(1'b0);
    chk("sf_out_count", 32'(n_outv - n0), 16);
    chk("sf_en_count", 32'(n_en - e0), 33);
    chk("sf_zero_count", 32'(n_zero - z0), 17);
    chk("sf_latency_cyc", 32'(of_cyc - ff_cyc), 17);

    // two back-to-back frames
    n0 = n_outv; z0 = n_zero;
    repeat (32) cycle(1'b1);
    repeat (LAT + 4) cycle(1'b0);
    chk("b2b_out_count", 32'(n_outv - n0), 32);
    chk("b2b_zero_count", 32'(n_zero - z0), 17);
    chk("b2b_latency_adv", 32'(of_adv - ff_adv), 17);

    // stall at g=5
    repeat (5) cycle(1'b1);
    cycle(1'b0);
    chk("g5_phase", 32'(o_st_phase), 32'h1);
    chk("g5_tw", 32'(o_st_tw), 32'h01);
    cycle(1'b0);
    cycle(1'b0);
    chk("stall_hold_phase", 32'(o_st_phase), 32'h1);
    repeat (9) cycle(1'b1);
    cycle(1'b1);
    chk("g14_phase", 32'(o_st_phase), 32'h7);
    chk("g14_tw", 32'(o_st_tw), 32'h06);
    cycle(1'b1);
    repeat (LAT + 4) cycle(1'b0);
    chk("stall_latency_adv", 32'(of_adv - ff_adv), 17);
    chk("stall_latency_cyc", 32'(of_cyc - ff_cyc), 20);

    // reset mid-stream discards in-flight samples
    repeat (7) cycle(1'b1);
    repeat (3) rst_cycle();
    n0 = n_outv;
    repeat (LAT + 5) cycle(1'b0);
    chk("rst_no_out", 32'(n_outv - n0), 0);

    // new frame offered during flush
    n0 = n_outv;
    repeat (16) cycle(1'b1);
    repeat (3) cycle(1'b0);
    repeat (29) cycle(1'b1);
    repeat (LAT + 4) cycle(1'b0);
    chk("flush_new_out_count", 32'(n_outv - n0), 32);
    chk("flush_new_latency_adv", 32'(of_adv - ff_adv), 17);

    // random traffic with occasional resets
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        repeat (1 + $urandom_range(0, 2)) rst_cycle();
      end else begin
        cycle($urandom_range(0, 99) < 75);
      end
    end
    repeat (LAT + 4) cycle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
